// File: rtl/temp_bcd_frontend.sv
// Temperature monitor front end: signed sample in, delta from previous sample,
// both magnitudes converted to 3-digit BCD with a sequential double-dabble.
module temp_bcd_frontend #(
    parameter int WIDTH     = 10,
    parameter int EN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             sample_ready,
    output logic [3:0]       temp_value_ones,
    output logic [3:0]       temp_value_tens,
    output logic [3:0]       temp_value_huns,
    output logic             temp_value_sign,
    output logic [3:0]       temp_delta_ones,
    output logic [3:0]       temp_delta_tens,
    output logic [3:0]       temp_delta_huns,
    output logic             temp_delta_sign,
    output logic             en
);

    localparam int         BW      = WIDTH + 1;
    localparam logic [3:0] STEPS   = 4'(BW);
    localparam logic [3:0] EN_LAST = 4'(EN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [BW-1:0]    vbin_q, vbin_d;
    logic [BW-1:0]    dbin_q, dbin_d;
    logic [11:0]      vbcd_q, vbcd_d;
    logic [11:0]      dbcd_q, dbcd_d;
    logic             vsign_q, vsign_d;
    logic             dsign_q, dsign_d;
    logic [11:0]      vout_q, vout_d;
    logic [11:0]      dout_q, dout_d;
    logic             vsout_q, vsout_d;
    logic             dsout_q, dsout_d;

    logic signed [BW-1:0] delta;
    logic [BW-1:0]        draw;
    logic [WIDTH-1:0]     vabs;
    logic [BW-1:0]        dabs;
    logic [BW-1:0]        vmag;
    logic [BW-1:0]        dmag;
    logic [11:0]          vadj;
    logic [11:0]          dadj;

    function automatic logic [BW-1:0] sat999(input logic [BW-1:0] m);
        if (32'(m) > 32'd999) begin
            return BW'(10'd999);
        end
        return m;
    endfunction

    // Add-3 correction applied to every digit before the shift.
    function automatic logic [11:0] dd_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        delta = '0;
        if (have_prev_q) begin
            delta = $signed({sample[WIDTH-1], sample})
                  - $signed({prev_q[WIDTH-1], prev_q});
        end
        draw = delta;
        vabs = sample[WIDTH-1] ? (~sample + 1'b1) : sample;
        dabs = draw[BW-1] ? (~draw + 1'b1) : draw;
        vmag = sat999({1'b0, vabs});
        dmag = sat999(dabs);
        vadj = dd_adj(vbcd_q);
        dadj = dd_adj(dbcd_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (sample_valid) state_d = CONV;
            CONV: if (cnt_q == STEPS) state_d = HOLD;
            HOLD: if (cnt_q == EN_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        vbin_d      = vbin_q;
        dbin_d      = dbin_q;
        vbcd_d      = vbcd_q;
        dbcd_d      = dbcd_q;
        vsign_d     = vsign_q;
        dsign_d     = dsign_q;
        vout_d      = vout_q;
        dout_d      = dout_q;
        vsout_d     = vsout_q;
        dsout_d     = dsout_q;
        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    prev_d      = sample;
                    have_prev_d = 1'b1;
                    vbin_d      = vmag;
                    dbin_d      = dmag;
                    vbcd_d      = '0;
                    dbcd_d      = '0;
                    vsign_d     = sample[WIDTH-1];
                    dsign_d     = draw[BW-1];
                    cnt_d       = '0;
                end
            end
            CONV: begin
                if (cnt_q == STEPS) begin
                    vout_d  = vbcd_q;
                    dout_d  = dbcd_q;
                    vsout_d = vsign_q;
                    dsout_d = dsign_q;
                    cnt_d   = '0;
                end else begin
                    vbcd_d = {vadj[10:0], vbin_q[BW-1]};
                    dbcd_d = {dadj[10:0], dbin_q[BW-1]};
                    vbin_d = {vbin_q[BW-2:0], 1'b0};
                    dbin_d = {dbin_q[BW-2:0], 1'b0};
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            HOLD: cnt_d = cnt_q + 4'd1;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            vbin_q      <= '0;
            dbin_q      <= '0;
            vbcd_q      <= '0;
            dbcd_q      <= '0;
            vsign_q     <= 1'b0;
            dsign_q     <= 1'b0;
            vout_q      <= '0;
            dout_q      <= '0;
            vsout_q     <= 1'b0;
            dsout_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            vbin_q      <= vbin_d;
            dbin_q      <= dbin_d;
            vbcd_q      <= vbcd_d;
            dbcd_q      <= dbcd_d;
            vsign_q     <= vsign_d;
            dsign_q     <= dsign_d;
            vout_q      <= vout_d;
            dout_q      <= dout_d;
            vsout_q     <= vsout_d;
            dsout_q     <= dsout_d;
        end
    end

    always_comb begin
        sample_ready    = (state_q == IDLE);
        en              = (state_q == HOLD);
        temp_value_huns = vout_q[11:8];
        temp_value_tens = vout_q[7:4];
        temp_value_ones = vout_q[3:0];
        temp_value_sign = vsout_q;
        temp_delta_huns = dout_q[11:8];
        temp_delta_tens = dout_q[7:4];
        temp_delta_ones = dout_q[3:0];
        temp_delta_sign = dsout_q;
    end

endmodule

// File: tb/tb_temp_bcd_frontend.sv
// Scoreboard bench for temp_bcd_frontend: default instance plus an
// EN_CYCLES=1 instance for back-to-back strobe timing.
module tb_temp_bcd_frontend;

    localparam int W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         v0, v1;
    logic [W-1:0] s0, s1;
    logic         r0, r1, en0, en1;
    logic [3:0]   vo0, vt0, vh0, do0, dt0, dh0;
    logic [3:0]   vo1, vt1, vh1, do1, dt1, dh1;
    logic         vs0, ds0, vs1, ds1;

    temp_bcd_frontend #(.WIDTH(W), .EN_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(v0), .sample(s0), .sample_ready(r0),
        .temp_value_ones(vo0), .temp_value_tens(vt0),
        .temp_value_huns(vh0), .temp_value_sign(vs0),
        .temp_delta_ones(do0), .temp_delta_tens(dt0),
        .temp_delta_huns(dh0), .temp_delta_sign(ds0),
        .en(en0)
    );

    temp_bcd_frontend #(.WIDTH(W), .EN_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(v1), .sample(s1), .sample_ready(r1),
        .temp_value_ones(vo1), .temp_value_tens(vt1),
        .temp_value_huns(vh1), .temp_value_sign(vs1),
        .temp_delta_ones(do1), .temp_delta_tens(dt1),
        .temp_delta_huns(dh1), .temp_delta_sign(ds1),
        .en(en1)
    );

    typedef struct {
        int vmag;
        bit vs;
        int dmag;
        bit ds;
        int acc;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t e0, e1;
    int   tests = 0, fails = 0, cyc = 0;
    int   prev0 = 0, prev1 = 0;
    bit   hp0 = 0, hp1 = 0;
    bit   mon0 = 0;
    int   run0 = 0, run1 = 0, npulse0 = 0;
    logic en0_d = 1'b0, en1_d = 1'b0;
    logic [25:0] last0;
    logic [25:0] out0;
    logic [25:0] out1;

    assign out0 = {vh0, vt0, vo0, vs0, dh0, dt0, do0, ds0};
    assign out1 = {vh1, vt1, vo1, vs1, dh1, dt1, do1, ds1};

    always @(posedge clk) cyc++;

    function automatic int sat(int m);
        return (m > 999) ? 999 : m;
    endfunction

    function automatic int iabs(int m);
        return (m < 0) ? -m : m;
    endfunction

    function automatic logic [11:0] bcd3(int m);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic exp_t model(int v, int p, bit hp, int acc);
        exp_t e;
        int d;
        d      = hp ? (v - p) : 0;
        e.vmag = sat(iabs(v));
        e.vs   = (v < 0);
        e.dmag = sat(iabs(d));
        e.ds   = (d < 0);
        e.acc  = acc;
        return e;
    endfunction

    // Default instance: compare on each en rise, check width and stability.
    always @(negedge clk) begin
        if (en0 === 1'b1 && en0_d === 1'b0) begin
            npulse0++;
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL en0_unexpected at cyc %0d: queue empty", cyc);
            end else begin
                e0 = q0.pop_front();
                if ({vh0, vt0, vo0, vs0} !== {bcd3(e0.vmag), e0.vs}) begin
                    fails++;
                    $display("FAIL value0 got %h sign %b, exp %h sign %b",
                             {vh0, vt0, vo0}, vs0, bcd3(e0.vmag), e0.vs);
                end
                tests++;
                if ({dh0, dt0, do0, ds0} !== {bcd3(e0.dmag), e0.ds}) begin
                    fails++;
                    $display("FAIL delta0 got %h sign %b, exp %h sign %b",
                             {dh0, dt0, do0}, ds0, bcd3(e0.dmag), e0.ds);
                end
                tests++;
                if (cyc - e0.acc != W + 2) begin
                    fails++;
                    $display("FAIL latency0 got %0d, exp %0d",
                             cyc - e0.acc, W + 2);
                end
            end
        end else if (mon0) begin
            tests++;
            if (out0 !== last0) begin
                fails++;
                $display("FAIL stable0 got %h, exp %h", out0, last0);
            end
        end
        if (en0 === 1'b1) begin
            run0++;
        end else if (en0_d === 1'b1) begin
            tests++;
            if (run0 != 4) begin
                fails++;
                $display("FAIL enwidth0 got %0d, exp 4", run0);
            end
            run0 = 0;
        end
        last0 = out0;
        en0_d = en0;
    end

    // EN_CYCLES=1 instance.
    always @(negedge clk) begin
        if (en1 === 1'b1 && en1_d === 1'b0) begin
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL en1_unexpected at cyc %0d: queue empty", cyc);
            end else begin
                e1 = q1.pop_front();
                if (out1 !== {bcd3(e1.vmag), e1.vs, bcd3(e1.dmag), e1.ds}) begin
                    fails++;
                    $display("FAIL out1 got %h, exp %h", out1,
                             {bcd3(e1.vmag), e1.vs, bcd3(e1.dmag), e1.ds});
                end
                tests++;
                if (cyc - e1.acc != W + 2) begin
                    fails++;
                    $display("FAIL latency1 got %0d, exp %0d",
                             cyc - e1.acc, W + 2);
                end
            end
        end
        if (en1 === 1'b1) begin
            run1++;
        end else if (en1_d === 1'b1) begin
            tests++;
            if (run1 != 1) begin
                fails++;
                $display("FAIL enwidth1 got %0d, exp 1", run1);
            end
            run1 = 0;
        end
        en1_d = en1;
    end

    task automatic send0(input int v);
        bit done;
        done = 0;
        s0 = W'(v);
        v0 = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            if (r0) begin
                q0.push_back(model(v, prev0, hp0, cyc + 1));
                prev0 = v;
                hp0   = 1;
                done  = 1;
            end
            @(negedge clk);
        end
        v0 = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL accept0 timeout got ready 0, exp 1");
        end
    endtask

    task automatic drain0();
        for (int k = 0; k < 60; k++) begin
            if (q0.size() == 0 && en0 === 1'b0) break;
            @(negedge clk);
        end
        tests++;
        if (q0.size() != 0 || en0 !== 1'b0) begin
            fails++;
            $display("FAIL drain0 got %0d pending en %b, exp 0 pending en 0",
                     q0.size(), en0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v0 = 1'b0; s0 = '0;
        v1 = 1'b0; s1 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q0.delete(); q1.delete();
        hp0 = 0; prev0 = 0; hp1 = 0; prev1 = 0;
        tests++;
        if ({out0, en0, r0} !== {26'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset0 got %h en %b rdy %b, exp 0 en 0 rdy 1",
                     out0, en0, r0);
        end
        tests++;
        if ({out1, en1, r1} !== {26'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset1 got %h en %b rdy %b, exp 0 en 0 rdy 1",
                     out1, en1, r1);
        end
        @(negedge clk);
        mon0 = 1;
    endtask

    task automatic test_first_sample();
        send0(235);
        drain0();
    endtask

    task automatic test_negative_delta();
        send0(-17);
        drain0();
    endtask

    task automatic test_saturation();
        send0(-511);
        drain0();
        send0(511);
        drain0();
    endtask

    task automatic test_backpressure();
        int n;
        n = npulse0;
        send0(7);
        repeat (3) @(negedge clk);
        s0 = W'(100);
        v0 = 1'b1;
        tests++;
        if (r0 !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready got %b, exp 0", r0);
        end
        @(negedge clk);
        v0 = 1'b0;
        tests++;
        if (r0 !== 1'b0) begin
            fails++;
            $display("FAIL bp_ready2 got %b, exp 0", r0);
        end
        send0(100);
        drain0();
        repeat (20) @(negedge clk);
        tests++;
        if (npulse0 - n != 2) begin
            fails++;
            $display("FAIL bp_pulses got %0d, exp 2", npulse0 - n);
        end
    endtask

    task automatic test_reset_mid_conv();
        int n;
        send0(300);
        repeat (4) @(negedge clk);
        mon0 = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        hp0 = 0; prev0 = 0; hp1 = 0; prev1 = 0;
        n = npulse0;
        tests++;
        if ({out0, en0, r0} !== {26'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL midrst got %h en %b rdy %b, exp 0 en 0 rdy 1",
                     out0, en0, r0);
        end
        @(negedge clk);
        mon0 = 1;
        repeat (20) @(negedge clk);
        tests++;
        if (npulse0 != n) begin
            fails++;
            $display("FAIL midrst_en got %0d pulses, exp 0", npulse0 - n);
        end
        send0(40);
        drain0();
    endtask

    task automatic test_min_strobe();
        int vals[5] = '{50, -60, 511, -512, 0};
        int idx, lastacc;
        idx = 0;
        lastacc = 0;
        s1 = W'(vals[0]);
        v1 = 1'b1;
        for (int k = 0; k < 200 && idx < 5; k++) begin
            if (r1) begin
                q1.push_back(model(vals[idx], prev1, hp1, cyc + 1));
                prev1 = vals[idx];
                hp1   = 1;
                if (idx > 0) begin
                    tests++;
                    if (cyc + 1 - lastacc != 14) begin
                        fails++;
                        $display("FAIL period1 got %0d, exp 14",
                                 cyc + 1 - lastacc);
                    end
                end
                lastacc = cyc + 1;
                idx++;
                @(negedge clk);
                if (idx < 5) s1 = W'(vals[idx]);
                else v1 = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        v1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (q1.size() == 0 && en1 === 1'b0) break;
            @(negedge clk);
        end
        tests++;
        if (idx != 5 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain1 got %0d accepted %0d pending, exp 5 and 0",
                     idx, q1.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_sample();
        test_negative_delta();
        test_saturation();
        test_backpressure();
        test_reset_mid_conv();
        test_min_strobe();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/temp_bcd_frontend.md
# temp_bcd_frontend

Upstream stage of the temperature monitor. Accepts signed two's-complement temperature samples through a valid/ready handshake and computes the delta from the previous sample. Converts the magnitudes of both the sample and the delta to 3-digit BCD with a sequential shift-add-3 converter. Presents the digits, signs and an `en` strobe in the form the monitor consumes.

## Interface
- `WIDTH`, 10: sample width in bits, signed; legal range 4..10.
- `EN_CYCLES`, 4: cycles `en` stays high per update; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `sample_valid`  in  1  upstream has a sample on `sample`.
- `sample`  in  WIDTH  signed temperature, two's complement.
- `sample_ready`  out  1  block can accept a sample.
- `temp_value_ones/tens/huns`  out  4 each  BCD magnitude of the sample.
- `temp_value_sign`  out  1  1 = sample negative.
- `temp_delta_ones/tens/huns`  out  4 each  BCD magnitude of (sample − previous sample).
- `temp_delta_sign`  out  1  1 = delta negative.
- `en`  out  1  new-value strobe; its rising edge marks an update.

## Operation
- FSM states: IDLE → CONV → HOLD → IDLE.
- **IDLE**
  - `sample_ready`=1.
  - On `sample_valid && sample_ready`:
    - capture `sample`;
    - compute `delta = sample − prev` at WIDTH+1 bits, signed, with no overflow possible;
    - enter CONV.
- **First sample after reset** (`have_prev`=0): `delta` is forced to 0.
- **`prev` and `have_prev`:** at capture, `prev` ← sample and `have_prev` ← 1.
- **Magnitudes**
  - Both magnitudes are computed unsigned: `|sample|` in WIDTH bits, `|delta|` in WIDTH+1 bits.
  - If either magnitude exceeds 999, it saturates to 999.
  - Sign bits are taken from the raw signed values. Zero is positive (sign=0).
- **CONV**
  - Two shift-add-3 (double-dabble) converters run in parallel, one bit per cycle, MSB first.
  - Step count is exactly WIDTH+1 cycles for both converters; `|sample|` is zero-extended.
  - Before each shift, add 3 to any BCD digit ≥ 5.
  - A step counter terminates CONV and the FSM enters HOLD.
- **HOLD**
  - On entry, all eight digit outputs and both signs load in the same edge. They are never updated piecemeal.
  - `en`=1 for exactly EN_CYCLES cycles, then `en`=0 and the FSM returns to IDLE.
- **Output stability:** outputs hold their values until the next HOLD entry. `en` is low at every other time.
- **Backpressure:**
  - `sample_ready`=0 in CONV and HOLD.
  - `sample_valid` in those states is ignored; upstream holds its data.
- **Reset** (`rst_n`=0 at a rising edge), from any state, including mid-CONV:
  - FSM → IDLE; `have_prev`=0; `prev`=0;
  - all digit and sign outputs = 0; `en`=0; `sample_ready`=1 from the first cycle after reset.
  - An in-flight conversion is discarded.

## Timing
- Accept edge = T. CONV occupies cycles T+1 .. T+WIDTH+1.
- Outputs and `en` rise after edge T+WIDTH+2: 12 clocks latency for WIDTH=10.
- `en` is high for EN_CYCLES cycles.
- `sample_ready` returns high on the cycle after `en` falls.
- Minimum sample period is WIDTH+2+EN_CYCLES+1 cycles: 17 for defaults.
- `en` always has at least one low cycle between updates, so each update produces a distinct rising edge.
- A sign change and its new digits appear in the same cycle as the `en` rise, never before it.

## Test plan
- **First sample.** Reset, then send `sample`=+235 → digits 2/3/5, value sign 0, delta 0/0/0 sign 0. `en` high for 4 cycles starting 12 cycles after accept.
- **Negative delta.** Follow with −17 → value 0/1/7 sign 1; delta 2/5/2 sign 1. The sign and digits change on the same edge as the `en` rise.
- **Delta saturation.** Send −511 then +511 → value 5/1/1 sign 0; delta 1022 saturates to 9/9/9 sign 0.
- **Backpressure.** Pulse `sample_valid` with +100 during CONV → ignored, `sample_ready`=0, outputs unchanged. The same sample held until IDLE is accepted once.
- **Reset mid-conversion.** Assert `rst_n`=0 for 1 cycle in CONV → no `en` pulse, outputs 0. The next sample +40 is treated as first: delta 0/0/0.
- **Minimum strobe width.** With EN_CYCLES=1 and samples back-to-back with `sample_valid` held high → `en` pulses of exactly 1 cycle separated by ≥1 low cycle. Accepts occur every 14 cycles.
